// File: rtl/viterbi_frame_sched_if.sv
// Request/result handshake bundle for viterbi_frame_sched.
// master = frame sources and result sink, slave = scheduler.
interface viterbi_frame_sched_if #(
  parameter int FRAME_BITS = 7,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 1
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*2*FRAME_BITS-1:0] req_data;
  logic                            res_valid;
  logic                            res_ready;
  logic [FRAME_BITS-1:0]           res_data;
  logic [ID_W-1:0]                 res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/viterbi_frame_sched.sv
// Shares one serial Viterbi decoder between NUM_REQ frame sources.
// VITERBI_SCHED_FIXED_PRIO_EN: fixed priority instead of round-robin.
module viterbi_frame_sched #(
  parameter int FRAME_BITS = 7,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 1,
  parameter int TIMEOUT    = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  viterbi_frame_sched_if.slave  bus,
  output logic                  dec_x,
  output logic                  dec_sof,
  input  logic                  dec_ready,
  input  logic                  dec_y,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int CW = 2 * FRAME_BITS;
  localparam int BW = $clog2(CW + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nx;
  logic [ID_W-1:0]       id;
  logic [CW-1:0]         sel_data;
  logic [CW-1:0]         tx;
  logic [FRAME_BITS-1:0] rx;
  logic [BW-1:0]         bit_cnt;
  logic [7:0]            wait_cnt;
  logic                  found;
  logic                  send_done;
  logic                  recv_done;
  logic                  wait_tmo;
  int                    idx;

  // Search starts at ptr and wraps; first valid source wins.
  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    sel_data = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        sel_data = bus.req_data[idx*CW +: CW];
      end
    end
  end

`ifdef VITERBI_SCHED_FIXED_PRIO_EN
  assign ptr_nx = '0;
`else
  assign ptr_nx = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0
                : gnt_id + 1'b1;
`endif

  assign send_done = (bit_cnt == BW'(CW));
  assign recv_done = (bit_cnt == BW'(FRAME_BITS - 1));
  assign wait_tmo  = (wait_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = SEND;
      SEND: if (send_done) state_nx = WAIT;
      WAIT: begin
        if (dec_ready)     state_nx = RECV;
        else if (wait_tmo) state_nx = IDLE;
      end
      RECV: if (recv_done) state_nx = OUT;
      OUT:  if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      id       <= '0;
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      dec_x    <= 1'b0;
      dec_sof  <= 1'b0;
    end else begin
      dec_sof <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx      <= sel_data >> 1;
            dec_x   <= sel_data[0];
            dec_sof <= 1'b1;
            bit_cnt <= BW'(1);
            id      <= gnt_id;
            ptr     <= ptr_nx;
          end
        end
        SEND: begin
          if (send_done) begin
            dec_x    <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
          end else begin
            dec_x   <= tx[0];
            tx      <= tx >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT: begin
          // Result bits enter at the top so bit 0 lands at rx[0].
          if (dec_ready) begin
            rx      <= {dec_y, rx[FRAME_BITS-1:1]};
            bit_cnt <= BW'(1);
          end else if (!wait_tmo) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RECV: begin
          rx <= {dec_y, rx[FRAME_BITS-1:1]};
          if (!recv_done) bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) ? gnt : '0;
  assign bus.res_valid = (state == OUT);
  assign bus.res_data  = rx;
  assign bus.res_id    = id;
  assign busy          = (state != IDLE);
  assign err_timeout   = (state == WAIT) && !dec_ready
                      && wait_tmo;

endmodule
